da_lut_loader: RTL and testbench
================================

// Module: da_lut_loader
// PURPOSE
//  Writer side of the distributed-arithmetic FIR coefficient-ROM port (CIN/CADDR/CLOAD).
//  - Accepts 64 signed tap coefficients as a ready/valid stream, 8 taps per bank.
//  - For each bank, generates all 256 partial-sum LUT entries and writes them, one per cycle.
//  - Feeds the DA core's SRAM bank before filtering starts; the DA core reads that bank via its A7..A0 address slices.
// PARAMETERS
//  COEF_W   16  coefficient width, two's complement
//  NTAP     8   taps per bank; LUT depth is 2**NTAP
//  NBANK    8   number of banks
//  OUT_W    19  LUT entry width; must equal COEF_W + log2(NTAP)
//  ADDR_W   11  CADDR width; must equal log2(NBANK) + NTAP
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       synchronous, active-high
//  start       in   1       pulse; begins a full load (ignored unless IDLE)
//  coef_valid  in   1       coef_data valid
//  coef_ready  out  1       loader accepts coef_data this cycle
//  coef_data   in   COEF_W  coefficient; order is tap 0..63
//  CIN         out  OUT_W   LUT entry to write
//  CADDR       out  ADDR_W  write address {bank[2:0], entry[7:0]}
//  CLOAD       out  1       write strobe; CIN/CADDR valid only while high
//  busy        out  1       high from accepted start until done
//  done        out  1       one-cycle pulse after final write
// BEHAVIOUR
//  Reset values and timing
//   - Reset: all outputs 0; FSM goes to IDLE; bank and entry counters are 0.
//   - Reset mid-operation: same effect on the next edge. CLOAD is low on the following cycle, and any partial load is abandoned.
//  FSM: IDLE -> COLLECT -> WRITE -> (COLLECT | DONE) -> IDLE
//   - IDLE: on start=1, set bank=0, tap=0, busy=1, go to COLLECT.
//   - COLLECT: coef_ready=1.
//     - Each cycle with coef_valid&coef_ready stores coef_data into tap register c[tap], then tap++.
//     - When the 8th tap is accepted, go to WRITE. First write is on the next cycle.
//     - coef_valid gaps stall the FSM; no timeout.
//   - WRITE: coef_ready=0; CLOAD=1 for exactly 256 consecutive cycles, entry=0..255.
//     - CADDR={bank,entry}.
//     - CIN = sum of sign-extended c[j] over every j where entry[j]=1; entry 0 writes 0.
//     - The sum is combinational from registered c[], and CIN/CADDR/CLOAD are registered outputs.
//     - After entry 255: if bank<7, then bank++, tap=0, go to COLLECT (CLOAD low). Otherwise go to DONE.
//   - DONE: done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
//  Address/tap mapping and arithmetic
//   - Address bit j of bank b corresponds to tap 8*b+j.
//   - Sum width is OUT_W; max magnitude 8*2^15 = 2^18, so the sum never overflows. No saturation or rounding.
//  Boundary rules
//   - start while busy is ignored.
//   - coef_valid while coef_ready=0 is ignored; the data is not consumed.
//   - start and reset in the same cycle: reset wins.
//   - Entry counter wraps 255->0 only at the bank transition.
//  Throughput
//   - Minimum full load is 8*(8+256)=2112 cycles from the first accepted coef to the last write.
//   - done follows the last write by 1 cycle.
// TESTING
//  T1 reset
//   - Hold reset 3 cycles with start=1 and coef_valid=1.
//   - Expect CLOAD=coef_ready=busy=done=0, CIN=0, CADDR=0.
//  T2 all coefs=+1, no gaps
//   - Expect 2048 writes total; CIN=popcount(entry), e.g. CADDR=0x0FF -> CIN=8.
//   - Expect CLOAD low exactly 8 cycles between banks, and done at cycle 2113.
//  T3 all coefs=16'h8000
//   - Expect CADDR 0x7FF -> CIN=19'h40000, and CADDR 0x001 -> CIN=19'h78000.
//  T4 bank0 taps {16'h8000, 7x16'h7FFF}
//   - Expect CADDR 0x0FF -> CIN=196601 (19'h2FFF9), and CADDR 0x0FE -> CIN=229369.
//  T5 random coef_valid gaps (50%)
//   - Expect exactly 64 handshakes and no write while coef_ready=1.
//   - CIN must match a reference model on all 2048 writes.
//  T6 reset at bank 3, entry 100; then start again
//   - Expect CLOAD=0 on the next cycle and busy=0.
//   - The new load's first write is at CADDR 0x000.
//   - start pulsed during WRITE has no effect.

Source files
------------

// File: rtl/da_lut_loader.sv
// da_lut_loader: collects NTAP signed taps per bank, then writes that bank's
// 2**NTAP distributed-arithmetic partial sums into the coefficient ROM.
//
// state   | meaning
// IDLE    | waiting for start
// COLLECT | accepting this bank's taps (coef_ready high)
// WRITE   | one LUT entry per cycle, CLOAD high
// DONE    | done pulse on the outputs; busy drops next cycle
module da_lut_loader #(
  parameter int COEF_W = 16,
  parameter int NTAP   = 8,
  parameter int NBANK  = 8,
  parameter int OUT_W  = 19,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic [COEF_W-1:0] coef_data,
  output logic [OUT_W-1:0]  CIN,
  output logic [ADDR_W-1:0] CADDR,
  output logic              CLOAD,
  output logic              busy,
  output logic              done
);

  localparam int BANK_W = $clog2(NBANK);
  localparam int TAP_W  = $clog2(NTAP);
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NBANK - 1);
  localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(NTAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [BANK_W-1:0]        bank_q, bank_d;
  logic [TAP_W-1:0]         tap_q, tap_d;
  logic [NTAP-1:0]          entry_q, entry_d, entry_nxt;
  logic signed [COEF_W-1:0] c_q [NTAP];
  logic signed [COEF_W-1:0] c_d [NTAP];
  logic                     ready_q, ready_d;
  logic                     cload_q, cload_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [OUT_W-1:0]         cin_q, cin_d;
  logic [ADDR_W-1:0]        caddr_q, caddr_d;
  logic signed [OUT_W-1:0]  lut_sum;

  // entry_q is the entry currently on CADDR; the sum is prepared for the next one
  always_comb begin
    entry_nxt = entry_q + 1'b1;
    lut_sum   = '0;
    for (int j = 0; j < NTAP; j++) begin
      if (entry_nxt[j]) lut_sum = lut_sum + OUT_W'(c_q[j]);
    end
  end

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    tap_d   = tap_q;
    entry_d = entry_q;
    c_d     = c_q;
    ready_d = 1'b0;
    cload_d = 1'b0;
    cin_d   = '0;
    caddr_d = '0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COLLECT;
          bank_d  = '0;
          tap_d   = '0;
          entry_d = '0;
          busy_d  = 1'b1;
          ready_d = 1'b1;
        end
      end
      S_COLLECT: begin
        ready_d = 1'b1;
        if (coef_valid && ready_q) begin
          c_d[tap_q] = coef_data;
          tap_d      = tap_q + 1'b1;
          if (tap_q == TAP_LAST) begin
            ready_d = 1'b0;
            state_d = S_WRITE;
            entry_d = '0;
            cload_d = 1'b1;
            cin_d   = '0;
            caddr_d = {bank_q, {NTAP{1'b0}}};
          end
        end
      end
      S_WRITE: begin
        if (entry_q == '1) begin
          entry_d = '0;
          if (bank_q == BANK_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            bank_d  = bank_q + 1'b1;
            tap_d   = '0;
            state_d = S_COLLECT;
            ready_d = 1'b1;
          end
        end else begin
          entry_d = entry_nxt;
          cload_d = 1'b1;
          cin_d   = lut_sum;
          caddr_d = {bank_q, entry_nxt};
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      bank_q  <= '0;
      tap_q   <= '0;
      entry_q <= '0;
      c_q     <= '{default: '0};
      ready_q <= 1'b0;
      cload_q <= 1'b0;
      cin_q   <= '0;
      caddr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      tap_q   <= tap_d;
      entry_q <= entry_d;
      c_q     <= c_d;
      ready_q <= ready_d;
      cload_q <= cload_d;
      cin_q   <= cin_d;
      caddr_q <= caddr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign coef_ready = ready_q;
  assign CLOAD      = cload_q;
  assign CIN        = cin_q;
  assign CADDR      = caddr_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_da_lut_loader.sv
// Scoreboard bench for da_lut_loader: the driver pushes the expected LUT writes
// of each bank once its taps are handed over; a negedge monitor checks every write.
module tb_da_lut_loader;

  logic        clk = 1'b0;
  logic        reset, start, coef_valid, coef_ready, CLOAD, busy, done;
  logic [15:0] coef_data;
  logic [18:0] CIN;
  logic [10:0] CADDR;

  da_lut_loader dut (
    .clk(clk), .reset(reset), .start(start), .coef_valid(coef_valid),
    .coef_ready(coef_ready), .coef_data(coef_data), .CIN(CIN), .CADDR(CADDR),
    .CLOAD(CLOAD), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] addr;
    logic [18:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         w;
  int          gaps[$];
  logic [18:0] seen [2048];
  int checks = 0, errors = 0;
  int cyc = 0, hs_cnt = 0, wr_cnt = 0, last_wr_cyc = 0, first_acc_cyc = 0;
  logic [10:0] first_addr;
  logic        done_prev = 1'b0;
  bit          abort = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: handshakes, write scoreboard, write/ready exclusion, done pulse width
  always @(negedge clk) begin
    if (!reset) begin
      if (coef_valid && coef_ready) begin
        if (hs_cnt == 0) first_acc_cyc = cyc;
        hs_cnt++;
      end
      if (CLOAD) begin
        checks++;
        if (coef_ready) begin
          errors++;
          $display("FAIL write_while_ready addr=%0h", CADDR);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write actual addr=%0h data=%0h required none", CADDR, CIN);
        end else begin
          w = exp_q.pop_front();
          if (CADDR !== w.addr || CIN !== w.data) begin
            errors++;
            $display("FAIL lut_write actual addr=%0h data=%0h required addr=%0h data=%0h",
                     CADDR, CIN, w.addr, w.data);
          end
        end
        seen[CADDR] = CIN;
        if (wr_cnt == 0) first_addr = CADDR;
        else if (cyc - last_wr_cyc > 1) gaps.push_back(cyc - last_wr_cyc - 1);
        wr_cnt++;
        last_wr_cyc = cyc;
      end
      if (done && done_prev) begin
        checks++;
        errors++;
        $display("FAIL done_width actual=2+ cycles required=1");
      end
      done_prev = done;
    end
  end

  task automatic clear_sb();
    exp_q.delete();
    gaps.delete();
    hs_cnt = 0;
    wr_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_coef(input logic [15:0] d, input int gap_pct);
    bit took = 1'b0;
    int n = 0;
    if (abort) return;
    while (!took) begin
      coef_valid = ($urandom_range(99) >= gap_pct);
      coef_data  = coef_valid ? d : 16'($urandom);
      @(negedge clk);
      took = coef_valid && coef_ready;
      @(posedge clk); #1;
      n++;
      if (!took && n > 2000) begin
        chk("coef_accept_timeout", 32'(n), 32'd0);
        abort = 1'b1;
        coef_valid = 1'b0;
        return;
      end
    end
    coef_valid = 1'b0;
  endtask

  // Reference model: entry e of bank b is the sum of the taps 8b+j whose bit j of e is set
  task automatic push_bank(input logic [15:0] cf[64], input int b);
    for (int e = 0; e < 256; e++) begin
      int  s = 0;
      wr_t x;
      for (int j = 0; j < 8; j++)
        if (((e >> j) & 1) == 1) s += int'($signed(cf[8*b+j]));
      x.addr = 11'(b * 256 + e);
      x.data = 19'(s);
      exp_q.push_back(x);
    end
  endtask

  task automatic make_coefs(input int mode, output logic [15:0] cf[64]);
    for (int i = 0; i < 64; i++) begin
      case (mode)
        0:       cf[i] = 16'h0001;
        1:       cf[i] = 16'h8000;
        2:       cf[i] = (i == 0) ? 16'h8000 : (i < 8) ? 16'h7FFF : 16'($urandom);
        default: cf[i] = 16'($urandom);
      endcase
    end
  endtask

  task automatic run_load(input int mode, input int gap_pct, input bit start_in_write);
    logic [15:0] cf[64];
    int n = 0, done_at = 0;
    bit got = 1'b0;
    make_coefs(mode, cf);
    clear_sb();
    pulse_start();
    for (int b = 0; b < 8; b++) begin
      for (int j = 0; j < 8; j++) send_coef(cf[8*b+j], gap_pct);
      if (!abort) push_bank(cf, b);
      if (start_in_write && b == 0) pulse_start();
    end
    while (!got && n < 3000) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        done_at = cyc;
      end
      n++;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("handshakes", 32'(hs_cnt), 32'd64);
    chk("write_count", 32'(wr_cnt), 32'd2048);
    chk("sb_left", 32'(exp_q.size()), 32'd0);
    chk("first_write_addr", 32'(first_addr), 32'h000);
    if (gap_pct == 0) begin
      chk("done_latency", 32'(done_at - first_acc_cyc), 32'd2112);
      chk("bank_gap_count", 32'(gaps.size()), 32'd7);
      foreach (gaps[i]) chk("bank_gap_len", 32'(gaps[i]), 32'd8);
    end
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_after_done", 32'(done), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic abort_load();
    logic [15:0] cf[64];
    int n = 0;
    make_coefs(3, cf);
    clear_sb();
    pulse_start();
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 8; j++) send_coef(cf[8*b+j], 0);
      if (!abort) push_bank(cf, b);
    end
    while (!(CLOAD && CADDR == 11'h364) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_bank3_entry100", 32'(CADDR), 32'h364);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_cload", 32'(CLOAD), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(coef_ready), 32'd0);
    @(posedge clk); #1;
    clear_sb();
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b1;
    coef_valid = 1'b1;
    coef_data  = 16'h1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cload", 32'(CLOAD), 32'd0);
    chk("rst_ready", 32'(coef_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cin", 32'(CIN), 32'd0);
    chk("rst_caddr", 32'(CADDR), 32'd0);
    @(posedge clk); #1;
    reset      = 1'b0;
    start      = 1'b0;
    coef_valid = 1'b0;
    @(posedge clk); #1;

    run_load(0, 0, 1'b0);
    chk("ones_0ff", 32'(seen[11'h0FF]), 32'd8);
    chk("ones_5a3", 32'(seen[11'h5A3]), 32'd4);

    run_load(1, 0, 1'b0);
    chk("min_7ff", 32'(seen[11'h7FF]), 32'h40000);
    chk("min_001", 32'(seen[11'h001]), 32'h78000);

    run_load(2, 0, 1'b0);
    chk("mixed_0ff", 32'(seen[11'h0FF]), 32'd196601);
    chk("mixed_0fe", 32'(seen[11'h0FE]), 32'd229369);

    run_load(3, 50, 1'b0);

    abort_load();
    run_load(3, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
